fetch_pc: RTL and testbench

FETCH_PC -- requirements
Module: fetch_pc

---
 rtl/fetch_pc_pkg.sv | 16 +
 rtl/fetch_ras.sv | 65 ++++++
 rtl/fetch_pc.sv | 105 ++++++++++
 tb/tb_fetch_pc.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared CPU fetch package: default fetch parameters and the redirect-kind encoding.
package fetch_pc_pkg;

    localparam int FETCH_AW        = 11;
    localparam int FETCH_STEP      = 1;
    localparam int FETCH_RESET_VEC = 0;
    localparam int FETCH_RAS_DEPTH = 4;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        BRANCH = 2'd1,
        RET    = 2'd2,
        CALL   = 2'd3
    } redirect_kind_e;

endpackage

// File: rtl/fetch_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module fetch_ras
    import fetch_pc_pkg::*;
#(
    parameter int AW    = FETCH_AW,
    parameter int DEPTH = FETCH_RAS_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          err
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [AW-1:0] mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] top_idx_s;
    logic [OW-1:0] occ_r;
    logic          err_r;

    // wr_ptr_r always names the next free slot, which is also the oldest entry once full
    assign top_idx_s = wr_ptr_r - PW'(1);
    assign top       = mem_r[top_idx_s];
    assign empty     = (occ_r == OW'(0));
    assign full      = (occ_r == OW'(DEPTH));
    assign err       = err_r;

    // Pointer, occupancy and sticky error; pop wins if both are requested
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            occ_r    <= OW'(0);
            err_r    <= 1'b0;
        end else if (pop) begin
            if (!empty) begin
                wr_ptr_r <= wr_ptr_r - PW'(1);
                occ_r    <= occ_r - OW'(1);
            end else begin
                err_r    <= 1'b1;
            end
        end else if (push) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
            if (full) begin
                err_r <= 1'b1;
            end else begin
                occ_r <= occ_r + OW'(1);
            end
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (!reset && !pop && push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_pc.sv
// Program-counter register with branch/return/call/stall priority and a return-address stack.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int AW        = FETCH_AW,
    parameter int STEP      = FETCH_STEP,
    parameter int RESET_VEC = FETCH_RESET_VEC,
    parameter int RAS_DEPTH = FETCH_RAS_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch_valid,
    input  logic [AW-1:0] branch_address,
    input  logic          call_valid,
    input  logic [AW-1:0] call_target,
    input  logic          ret_valid,
    output logic [AW-1:0] cnt,
    output logic          ras_empty,
    output logic          ras_full,
    output logic          ras_err
);

    redirect_kind_e kind_s;
    logic [AW-1:0]  cnt_r;
    logic [AW-1:0]  next_cnt_s;
    logic [AW-1:0]  seq_s;
    logic [AW-1:0]  ras_top_s;
    logic           push_s;
    logic           pop_s;

    assign cnt   = cnt_r;
    assign seq_s = cnt_r + AW'(STEP);

    // Select the single winning redirect for this cycle
    always_comb begin
        kind_s = NONE;
        if (branch_valid) begin
            kind_s = BRANCH;
        end else if (ret_valid) begin
            kind_s = RET;
        end else if (call_valid) begin
            kind_s = CALL;
        end else begin
            kind_s = NONE;
        end
    end

    // Next-PC mux and stack requests; a losing request never touches the stack
    always_comb begin
        next_cnt_s = cnt_r;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        case (kind_s)
            BRANCH: next_cnt_s = branch_address;
            RET: begin
                pop_s = 1'b1;
                if (!ras_empty) begin
                    next_cnt_s = ras_top_s;
                end else if (!stall) begin
                    next_cnt_s = seq_s;
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            CALL: begin
                push_s     = 1'b1;
                next_cnt_s = call_target;
            end
            NONE: begin
                if (!stall) begin
                    next_cnt_s = seq_s;
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            default: next_cnt_s = cnt_r;
        endcase
    end

    // Program-counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= AW'(RESET_VEC);
        end else begin
            cnt_r <= next_cnt_s;
        end
    end

    fetch_ras #(
        .AW    (AW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (seq_s),
        .top       (ras_top_s),
        .empty     (ras_empty),
        .full      (ras_full),
        .err       (ras_err)
    );

endmodule

// File: tb/tb_fetch_pc.sv
// Scoreboard bench for fetch_pc: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_pc;

    localparam int AW    = 11;
    localparam int MASK  = 2047;
    localparam int DEPTH = 4;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          branch_valid;
    logic [AW-1:0] branch_address;
    logic          call_valid;
    logic [AW-1:0] call_target;
    logic          ret_valid;
    logic [AW-1:0] cnt;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_err;

    typedef struct {
        int cnt;
        int empty;
        int full;
        int err;
    } exp_t;

    exp_t sb_q[$];
    int   ref_ras[$];
    int   ref_cnt;
    int   ref_err;
    int   n_cmp;
    int   n_bad;

    fetch_pc dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_valid   (branch_valid),
        .branch_address (branch_address),
        .call_valid     (call_valid),
        .call_target    (call_target),
        .ret_valid      (ret_valid),
        .cnt            (cnt),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .ras_err        (ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, advance the reference model, queue the expected post-edge state
    task automatic step(input bit rs, input bit st, input bit br, input int ba,
                        input bit cl, input int ct, input bit rt);
        exp_t e;
        reset          = rs;
        stall          = st;
        branch_valid   = br;
        branch_address = AW'(ba);
        call_valid     = cl;
        call_target    = AW'(ct);
        ret_valid      = rt;
        if (rs) begin
            ref_cnt = 0;
            ref_ras.delete();
            ref_err = 0;
        end else if (br) begin
            ref_cnt = ba & MASK;
        end else if (rt) begin
            if (ref_ras.size() > 0) begin
                ref_cnt = ref_ras.pop_back();
            end else begin
                ref_err = 1;
                if (!st) ref_cnt = (ref_cnt + 1) & MASK;
            end
        end else if (cl) begin
            if (ref_ras.size() == DEPTH) begin
                void'(ref_ras.pop_front());
                ref_err = 1;
            end
            ref_ras.push_back((ref_cnt + 1) & MASK);
            ref_cnt = ct & MASK;
        end else if (!st) begin
            ref_cnt = (ref_cnt + 1) & MASK;
        end
        e.cnt   = ref_cnt;
        e.empty = (ref_ras.size() == 0) ? 1 : 0;
        e.full  = (ref_ras.size() == DEPTH) ? 1 : 0;
        e.err   = ref_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: compare every post-edge output against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("cnt", int'(cnt), e.cnt);
                check("ras_empty", int'(ras_empty), e.empty);
                check("ras_full", int'(ras_full), e.full);
                check("ras_err", int'(ras_err), e.err);
            end
        end
    end

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        ref_cnt = 0;
        ref_err = 0;

        // Reset for two cycles, then free-run
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        idle(5);

        // Branch beats stall, then stall holds
        step(1'b0, 1'b0, 1'b1, 7, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 'h200, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

        // Call/return pair
        step(1'b0, 1'b0, 1'b1, 'h10, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 'h40, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);

        // Overflow then underflow
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b1, k * 'h100, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);

        // Simultaneous requests: branch wins, stack untouched
        step(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 'h300, 1'b0);
        step(1'b0, 1'b0, 1'b1, 'h123, 1'b1, 'h456, 1'b1);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 'h500, 1'b1);

        // Wrap from all-ones is silent
        step(1'b0, 1'b0, 1'b1, 'h7FF, 1'b0, 0, 1'b0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 7) == 0), int'($urandom_range(0, MASK)),
                 ($urandom_range(0, 4) == 0), int'($urandom_range(0, MASK)),
                 ($urandom_range(0, 4) == 0));
        end

        idle(1);
        reset        = 1'b0;
        branch_valid = 1'b0;
        call_valid   = 1'b0;
        ret_valid    = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
